// File: rtl/fp_align_grs80_pkg.sv
`default_nettype none
// ============================================================================
// Package : fp80_pkg
// Shared widths, types and amount clamping for the 80-bit FP datapath.
// Revision: 1.0
// ============================================================================
package fp80_pkg;

  localparam int WID80 = 80;
  localparam int AMTW  = 8;

  // Shifting by 82 or more pushes every original bit below the round position.
  localparam logic [AMTW-1:0] AMT_CLAMP = AMTW'(WID80 + 2);

  typedef logic [WID80-1:0] man80_t;

  typedef struct packed {
    logic g;
    logic r;
    logic s;
  } grs_t;

  function automatic logic [AMTW-1:0] clamp_amt(input logic [AMTW-1:0] amt);
    return (amt > AMT_CLAMP) ? AMT_CLAMP : amt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sticky_mask80.sv
`default_nettype none
// ============================================================================
// Module  : sticky_mask80
// Low-bit mask of the positions that fold into sticky for a clamped amount.
// Revision: 1.0
// ============================================================================
module sticky_mask80
  import fp80_pkg::*;
(
  input  logic [AMTW-1:0] ac_i,
  output man80_t          mask_o
);

  // Bit i lies below the round position exactly when ac > i + 2.
  for (genvar i = 0; i < WID80; i++) begin : g_mask
    assign mask_o[i] = (int'(ac_i) > i + 2);
  end

endmodule
`default_nettype wire

// File: rtl/fp_align_grs80.sv
`default_nettype none
// ============================================================================
// Module  : fp_align_grs80
// Two-stage right-shift aligner producing guard/round/sticky for the rounder.
// Revision: 1.0
// ============================================================================
module fp_align_grs80 #(
  parameter int WID  = 80,
  parameter int AMTW = 8,
  parameter int TAGW = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [WID-1:0]  man_i,
  input  logic [AMTW-1:0] amt_i,
  input  logic [TAGW-1:0] tag_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [WID-1:0]  man_o,
  output logic            g_o,
  output logic            r_o,
  output logic            s_o,
  output logic [TAGW-1:0] tag_o
);

  import fp80_pkg::grs_t;
  import fp80_pkg::man80_t;
  import fp80_pkg::clamp_amt;

  logic            va_q, va_d;
  logic [WID-1:0]  mana_q, mana_d;
  logic [AMTW-1:0] ac_q, ac_d;
  logic [TAGW-1:0] taga_q, taga_d;

  logic            vb_q, vb_d;
  logic [WID-1:0]  manb_q, manb_d;
  grs_t            grs_q, grs_d;
  logic [TAGW-1:0] tagb_q, tagb_d;

  logic            load_b;
  man80_t          smask;
  logic [WID+1:0]  shifted;

  assign load_b  = va_q & (~vb_q | ready_i);
  assign ready_o = ~va_q | ~vb_q | ready_i;

  sticky_mask80 u_sticky_mask (
    .ac_i   (ac_q),
    .mask_o (smask)
  );

  always_comb begin
    va_d   = va_q;
    mana_d = mana_q;
    ac_d   = ac_q;
    taga_d = taga_q;
    if (ready_o) begin
      va_d = valid_i;
      if (valid_i) begin
        mana_d = man_i;
        ac_d   = clamp_amt(amt_i);
        taga_d = tag_i;
      end
    end
  end

  // Two zero bits below the mantissa land the guard and round bits at [1:0].
  always_comb begin
    shifted = {mana_q, 2'b00} >> ac_q;
    vb_d    = vb_q;
    manb_d  = manb_q;
    grs_d   = grs_q;
    tagb_d  = tagb_q;
    if (load_b) begin
      vb_d    = 1'b1;
      manb_d  = shifted[WID+1:2];
      grs_d.g = shifted[1];
      grs_d.r = shifted[0];
      grs_d.s = |(mana_q & smask);
      tagb_d  = taga_q;
    end else if (ready_i) begin
      vb_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      va_q   <= 1'b0;
      mana_q <= '0;
      ac_q   <= '0;
      taga_q <= '0;
      vb_q   <= 1'b0;
      manb_q <= '0;
      grs_q  <= '0;
      tagb_q <= '0;
    end else begin
      va_q   <= va_d;
      mana_q <= mana_d;
      ac_q   <= ac_d;
      taga_q <= taga_d;
      vb_q   <= vb_d;
      manb_q <= manb_d;
      grs_q  <= grs_d;
      tagb_q <= tagb_d;
    end
  end

  assign valid_o = vb_q;
  assign man_o   = manb_q;
  assign g_o     = grs_q.g;
  assign r_o     = grs_q.r;
  assign s_o     = grs_q.s;
  assign tag_o   = tagb_q;

endmodule
`default_nettype wire
